// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register with a skid buffer.
// The main register always drives the outputs. The skid register catches
// the one extra entry that can arrive while the head is stalled. Because of
// that, in_ready depends only on registered state and flush.
module pipe_stage_reg #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_OPS    = 2,
  parameter int                    INSN_WIDTH = 32,
  parameter logic [INSN_WIDTH-1:0] NOP_INSN   = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_OPS*DATA_WIDTH-1:0] ops_in,
  input  logic [INSN_WIDTH-1:0]         insn_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_OPS*DATA_WIDTH-1:0] ops_out,
  output logic [INSN_WIDTH-1:0]         insn_out,
  output logic [1:0]                    occupancy
);

  localparam int OPS_WIDTH = NUM_OPS * DATA_WIDTH;

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_stateNext;

  logic [OPS_WIDTH-1:0]  r_mainOps;
  logic [INSN_WIDTH-1:0] r_mainInsn;
  logic                  r_mainValid;
  logic [OPS_WIDTH-1:0]  r_skidOps;
  logic [INSN_WIDTH-1:0] r_skidInsn;
  logic                  r_skidValid;

  logic [OPS_WIDTH-1:0]  w_mainOpsNext;
  logic [INSN_WIDTH-1:0] w_mainInsnNext;
  logic                  w_mainValidNext;
  logic [OPS_WIDTH-1:0]  w_skidOpsNext;
  logic [INSN_WIDTH-1:0] w_skidInsnNext;
  logic                  w_skidValidNext;

  logic                  w_accept;
  logic                  w_drain;

  // Handshake qualifiers. These are deliberately free of any in_valid or
  // out_ready path into in_ready.
  assign in_ready = !r_skidValid && !flush;
  assign w_accept = in_valid && in_ready;
  assign w_drain  = r_mainValid && out_ready;

  // Next-state and next-register logic. Every register holds by default.
  // Flush overrides everything, but a drain on the same edge still counts
  // downstream.
  always_comb begin
    w_stateNext     = r_state;
    w_mainOpsNext   = r_mainOps;
    w_mainInsnNext  = r_mainInsn;
    w_mainValidNext = r_mainValid;
    w_skidOpsNext   = r_skidOps;
    w_skidInsnNext  = r_skidInsn;
    w_skidValidNext = r_skidValid;

    unique case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_stateNext     = ONE;
          w_mainOpsNext   = ops_in;
          w_mainInsnNext  = insn_in;
          w_mainValidNext = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_drain) begin
          w_mainOpsNext   = ops_in;
          w_mainInsnNext  = insn_in;
        end else if (w_accept) begin
          w_stateNext     = FULL;
          w_skidOpsNext   = ops_in;
          w_skidInsnNext  = insn_in;
          w_skidValidNext = 1'b1;
        end else if (w_drain) begin
          w_stateNext     = EMPTY;
          w_mainValidNext = 1'b0;
        end
      end
      FULL: begin
        if (w_drain) begin
          w_stateNext     = ONE;
          w_mainOpsNext   = r_skidOps;
          w_mainInsnNext  = r_skidInsn;
          w_skidOpsNext   = '0;
          w_skidInsnNext  = NOP_INSN;
          w_skidValidNext = 1'b0;
        end
      end
      default: begin
        w_stateNext     = EMPTY;
        w_mainValidNext = 1'b0;
        w_skidValidNext = 1'b0;
      end
    endcase

    if (flush) begin
      w_stateNext     = EMPTY;
      w_mainOpsNext   = '0;
      w_mainInsnNext  = NOP_INSN;
      w_mainValidNext = 1'b0;
      w_skidOpsNext   = '0;
      w_skidInsnNext  = NOP_INSN;
      w_skidValidNext = 1'b0;
    end
  end

  // State and storage registers. Synchronous reset takes priority over all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_mainOps   <= '0;
      r_mainInsn  <= NOP_INSN;
      r_mainValid <= 1'b0;
      r_skidOps   <= '0;
      r_skidInsn  <= NOP_INSN;
      r_skidValid <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_mainOps   <= w_mainOpsNext;
      r_mainInsn  <= w_mainInsnNext;
      r_mainValid <= w_mainValidNext;
      r_skidOps   <= w_skidOpsNext;
      r_skidInsn  <= w_skidInsnNext;
      r_skidValid <= w_skidValidNext;
    end
  end

  assign out_valid = r_mainValid;
  assign ops_out   = r_mainOps;
  assign insn_out  = r_mainInsn;
  assign occupancy = r_state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg.
// Two instances with different parameter sets share one stimulus stream.
// The reference model is simply a queue of accepted entries.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [63:0] ops;
    logic [31:0] insn;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        inValid = 1'b0;
  logic        outReady = 1'b0;
  logic [63:0] stimOps = '0;
  logic [31:0] stimInsn = '0;

  logic        inReady0, outValid0;
  logic [63:0] opsOut0;
  logic [31:0] insnOut0;
  logic [1:0]  occ0;

  logic        inReady1, outValid1;
  logic [47:0] opsOut1;
  logic [23:0] insnOut1;
  logic [1:0]  occ1;

  ent_t        q[$];
  int          curOcc = 0;
  bit          monEn = 1'b0;
  bit          lastAcc = 1'b0;
  int          dutDrains = 0;
  int          checks = 0;
  int          failures = 0;
  logic [63:0] expOps = '0;
  logic [31:0] expInsn0 = 32'h0;
  logic [23:0] expInsn1 = 24'h000013;

  always #5 clk = ~clk;

  pipe_stage_reg dut0 (
    .clk(clk), .reset(rst), .flush(flush),
    .in_valid(inValid), .in_ready(inReady0),
    .ops_in(stimOps), .insn_in(stimInsn),
    .out_valid(outValid0), .out_ready(outReady),
    .ops_out(opsOut0), .insn_out(insnOut0), .occupancy(occ0)
  );

  pipe_stage_reg #(
    .DATA_WIDTH(16), .NUM_OPS(3), .INSN_WIDTH(24), .NOP_INSN(24'h000013)
  ) dut1 (
    .clk(clk), .reset(rst), .flush(flush),
    .in_valid(inValid), .in_ready(inReady1),
    .ops_in(stimOps[47:0]), .insn_in(stimInsn[23:0]),
    .out_valid(outValid1), .out_ready(outReady),
    .ops_out(opsOut1), .insn_out(insnOut1), .occupancy(occ1)
  );

  // One comparison, with a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // 16-bit lanes v, v+0x100, ... make channel order visible in both packings.
  function automatic logic [63:0] mkOps(input int v);
    logic [63:0] r;
    for (int k = 0; k < 4; k++) r[k*16 +: 16] = 16'(v + k * 256);
    return r;
  endfunction

  // Apply inputs for the coming edge, then update the model for that edge.
  // The monitor has already consumed any drained head at the negedge.
  task automatic applyStimulus(input logic r, input logic f, input logic v, input logic o,
                               input logic [63:0] ops, input logic [31:0] insn);
    ent_t e;
    rst = r; flush = f; inValid = v; outReady = o; stimOps = ops; stimInsn = insn;
    @(negedge clk);
    #1;
    lastAcc = v && !f && !r && (curOcc < 2);
    if (r || f) q.delete();
    else if (lastAcc) begin
      e.ops = ops; e.insn = insn;
      q.push_back(e);
    end
    if (q.size() != 0) begin
      expOps = q[0].ops; expInsn0 = q[0].insn; expInsn1 = q[0].insn[23:0];
    end else if (r || f) begin
      expOps = '0; expInsn0 = 32'h0; expInsn1 = 24'h000013;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare visible state with the model, then pop a drained head.
  always @(negedge clk) begin
    if (monEn) begin
      ent_t e;
      curOcc = q.size();
      checkOutput("out_valid0", 64'(outValid0), 64'(curOcc != 0));
      checkOutput("out_valid1", 64'(outValid1), 64'(curOcc != 0));
      checkOutput("occupancy0", 64'(occ0), 64'(curOcc));
      checkOutput("occupancy1", 64'(occ1), 64'(curOcc));
      checkOutput("in_ready0", 64'(inReady0), 64'(curOcc < 2 && !flush));
      checkOutput("in_ready1", 64'(inReady1), 64'(curOcc < 2 && !flush));
      checkOutput("ops_out0", opsOut0, expOps);
      checkOutput("ops_out1", 64'(opsOut1), 64'(expOps[47:0]));
      checkOutput("insn_out0", 64'(insnOut0), 64'(expInsn0));
      checkOutput("insn_out1", 64'(insnOut1), 64'(expInsn1));
      if (outValid0 && outReady && !rst) dutDrains++;
      if (curOcc != 0 && outReady && !rst) begin
        e = q.pop_front();
        checkOutput("drain_ops0", opsOut0, e.ops);
        checkOutput("drain_insn0", 64'(insnOut0), 64'(e.insn));
        checkOutput("drain_ops1", 64'(opsOut1), 64'(e.ops[47:0]));
        checkOutput("drain_insn1", 64'(insnOut1), 64'(e.insn[23:0]));
      end
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  // Stimulus sequence.
  initial begin
    int v;
    int d0;
    int g;
    @(posedge clk);
    #1;
    monEn = 1'b1;
    applyStimulus(1, 0, 0, 0, '0, '0);
    applyStimulus(1, 0, 0, 0, '0, '0);

    // Single entry through an empty stage.
    applyStimulus(0, 0, 1, 1, {32'h2, 32'h1}, 32'hABCD);
    applyStimulus(0, 0, 0, 1, '0, '0);
    applyStimulus(0, 0, 0, 0, '0, '0);

    // Stalled stream: only two entries fit, then drain one per cycle.
    v = 1;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(0, 0, 1, 0, mkOps(v), 32'(v));
      if (lastAcc) v++;
    end
    checkOutput("stream_stalled_accepts", 64'(v - 1), 64'd2);
    d0 = dutDrains;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(0, 0, 1'(v <= 10), 1, mkOps(v), 32'(v));
      if (lastAcc) v++;
    end
    checkOutput("stream_back_to_back_drains", 64'(dutDrains - d0), 64'd10);
    applyStimulus(0, 0, 0, 0, '0, '0);

    // Random traffic with occasional flush.
    for (int c = 0; c < 1000; c++) begin
      applyStimulus(0, 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom);
    end
    g = 0;
    while (q.size() != 0 && g < 20) begin
      applyStimulus(0, 0, 0, 1, '0, '0);
      g++;
    end
    checkOutput("random_drain_budget", 64'(q.size()), 64'd0);

    // Flush while full, with a competing input that must vanish.
    applyStimulus(0, 0, 1, 0, mkOps(21), 32'h21);
    applyStimulus(0, 0, 1, 0, mkOps(22), 32'h22);
    applyStimulus(0, 1, 1, 0, 64'hDEAD_BEEF_DEAD_BEEF, 32'hDEAD);
    applyStimulus(0, 0, 0, 1, '0, '0);
    applyStimulus(0, 0, 1, 1, mkOps(23), 32'h23);
    applyStimulus(0, 0, 0, 1, '0, '0);
    applyStimulus(0, 0, 0, 0, '0, '0);

    // Reset together with flush and drain while full.
    applyStimulus(0, 0, 1, 0, mkOps(31), 32'h31);
    applyStimulus(0, 0, 1, 0, mkOps(32), 32'h32);
    applyStimulus(1, 1, 1, 1, mkOps(33), 32'h33);
    applyStimulus(0, 0, 0, 1, '0, '0);
    applyStimulus(0, 0, 0, 0, '0, '0);

    monEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
